// File: rtl/d_pipe_pkg.sv
// Shared constants and helpers for the d_pipe delay line.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package d_pipe_pkg;

    localparam int D_PIPE_WIDTH_DEF = 8;
    localparam int D_PIPE_DEPTH_DEF = 4;

    // Wide enough to hold every count from 0 to depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One delay-line stage: a data register plus its valid flop.
// Latency: 1 enabled cycle.
// Backpressure: holds while en is low; flush clears valid and leaves the data alone.
module d_pipe_stage
    import d_pipe_pkg::*;
#(
    parameter int               WIDTH       = D_PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_dat,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q_dat,
    output logic             q_vld
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (en) begin
            data_d = d_dat;
            vld_d  = d_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_dat = data_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/d_pipe_sync_reset.sv
// Stallable DEPTH-stage delay line with per-stage valid, flush and occupancy count.
// Latency: DEPTH enabled cycles from D to Q; all outputs are registered.
// Backpressure: en low freezes every stage and the count; no ready is returned upstream.
module d_pipe_sync_reset
    import d_pipe_pkg::*;
#(
    parameter int               WIDTH       = D_PIPE_WIDTH_DEF,
    parameter int               DEPTH       = D_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         D,
    input  logic                     d_valid,
    output logic [WIDTH-1:0]         Q,
    output logic                     q_valid,
    output logic [occ_w(DEPTH)-1:0]  occupancy,
    output logic                     busy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] stg_dat [DEPTH];
    logic             stg_vld [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] in_dat;
        logic             in_vld;

        if (i == 0) begin : g_head
            assign in_dat = D;
            assign in_vld = d_valid;
        end else begin : g_body
            assign in_dat = stg_dat[i-1];
            assign in_vld = stg_vld[i-1];
        end

        d_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .flush (flush),
            .d_dat (in_dat),
            .d_vld (in_vld),
            .q_dat (stg_dat[i]),
            .q_vld (stg_vld[i])
        );
    end

    logic [OCC_W-1:0] occ_d, occ_q;

    // Incremental count: a word entering and one leaving on the same edge cancel out.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(stg_vld[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Q         = stg_dat[DEPTH-1];
    assign q_valid   = stg_vld[DEPTH-1];
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_d_pipe_sync_reset.sv
// Bench for d_pipe_sync_reset: a DEPTH=4 and a DEPTH=1 instance share one stimulus stream,
// checked against queue-based models of the pipe contents.
module tb_d_pipe_sync_reset;

    logic       clk = 1'b0;
    logic       reset, en, flush, d_valid;
    logic [7:0] D;

    logic [7:0] q4, q1;
    logic       qv4, qv1, busy4, busy1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] dat;
        logic       vld;
    } ent_t;

    ent_t p4[$];
    ent_t p1[$];

    always #5 clk = ~clk;

    d_pipe_sync_reset #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .D(D), .d_valid(d_valid),
        .Q(q4), .q_valid(qv4), .occupancy(occ4), .busy(busy4)
    );

    d_pipe_sync_reset #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A)) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .D(D), .d_valid(d_valid),
        .Q(q1), .q_valid(qv1), .occupancy(occ1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_valid(input ent_t p[$]);
        int n = 0;
        foreach (p[i]) if (p[i].vld) n++;
        return n;
    endfunction

    // Pipe contents as a list of words, newest at the front, oldest (the one on Q) at the back.
    task automatic model_clock(input logic r, input logic e, input logic f,
                               input logic [7:0] d, input logic dv);
        ent_t t;
        if (r) begin
            p4.delete();
            p1.delete();
            for (int i = 0; i < 4; i++) begin
                t.dat = 8'h00; t.vld = 1'b0; p4.push_back(t);
            end
            t.dat = 8'h5A; t.vld = 1'b0; p1.push_back(t);
        end else if (f) begin
            foreach (p4[i]) begin t = p4[i]; t.vld = 1'b0; p4[i] = t; end
            foreach (p1[i]) begin t = p1[i]; t.vld = 1'b0; p1[i] = t; end
        end else if (e) begin
            t.dat = d; t.vld = dv;
            p4.push_front(t); void'(p4.pop_back());
            p1.push_front(t); void'(p1.pop_back());
        end
    endtask

    task automatic check_all();
        int c4, c1;
        c4 = count_valid(p4);
        c1 = count_valid(p1);
        chk("q4",        32'(q4),    32'(p4[3].dat));
        chk("q_valid4",  32'(qv4),   32'(p4[3].vld));
        chk("occ4",      32'(occ4),  32'(c4));
        chk("busy4",     32'(busy4), 32'(c4 != 0));
        chk("occ4_max",  32'(occ4 <= 3'd4), 32'd1);
        chk("q1",        32'(q1),    32'(p1[0].dat));
        chk("q_valid1",  32'(qv1),   32'(p1[0].vld));
        chk("occ1",      32'(occ1),  32'(c1));
        chk("busy1",     32'(busy1), 32'(c1 != 0));
    endtask

    task automatic step(input logic r, input logic e, input logic f,
                        input logic [7:0] d, input logic dv);
        reset = r; en = e; flush = f; D = d; d_valid = dv;
        @(posedge clk);
        model_clock(r, e, f, d, dv);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] held;
        model_clock(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset dominates a fully active input.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 8'hFF, 1);
            chk("rst_q",    32'(q4),    32'h00);
            chk("rst_busy", 32'(busy4), 32'd0);
            chk("rst_q1",   32'(q1),    32'h5A);
        end

        // Fill: A1 reaches Q after the 4th enabled edge.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'hA1 + 8'(i), 1);
            chk("fill_occ", 32'(occ4), 32'(i + 1));
        end
        chk("fill_q", 32'(q4), 32'hA1);
        step(0, 1, 0, 8'hA5, 1);
        chk("fill_q5", 32'(q4), 32'hA2);
        chk("fill_occ5", 32'(occ4), 32'd4);

        // Stall while full.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'h55, 1);
            chk("stall_q",   32'(q4),   32'hA2);
            chk("stall_occ", 32'(occ4), 32'd4);
        end
        step(0, 1, 0, 8'hA6, 1);
        chk("resume_q", 32'(q4), 32'hA3);

        // Flush together with enable: AA is dropped, Q keeps its value.
        held = q4;
        step(0, 1, 1, 8'hAA, 1);
        chk("flush_q",   32'(q4),   32'(held));
        chk("flush_occ", 32'(occ4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("flush_noaa", 32'(qv4), 32'd0);
        end

        // Bubbles.
        step(0, 1, 0, 8'h11, 1);
        step(0, 1, 0, 8'h22, 0);
        step(0, 1, 0, 8'h33, 1);
        step(0, 1, 0, 8'h44, 0);
        chk("bub4_q", 32'({qv4, q4}), 32'h111);
        step(0, 1, 0, 8'h45, 0);
        chk("bub5_q", 32'({qv4, q4}), 32'h022);
        step(0, 1, 0, 8'h46, 0);
        chk("bub6_q", 32'({qv4, q4}), 32'h133);
        step(0, 1, 0, 8'h47, 0);
        chk("bub_occ0", 32'(occ4), 32'd0);

        // Mid-stream reset while full.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hB1 + 8'(i), 1);
        chk("full_occ", 32'(occ4), 32'd4);
        step(1, 0, 0, 8'hC3, 1);
        chk("mrst_q",   32'(q4),   32'h00);
        chk("mrst_occ", 32'(occ4), 32'd0);
        chk("mrst_q1",  32'(q1),   32'h5A);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic r, e, f, dv;
            r  = ($urandom_range(63) == 0);
            f  = ($urandom_range(9) == 0);
            e  = ($urandom_range(3) != 0);
            dv = ($urandom_range(3) != 0);
            step(r, e, f, 8'($urandom), dv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/d_pipe_sync_reset.md
# d_pipe_sync_reset

Parametrised, stallable delay line of `DEPTH` stages, each a `WIDTH`-bit D register with synchronous active-high reset and a per-stage valid bit. It generalises the team's single-bit sync-reset D flip-flop into a multi-bit, multi-stage pipeline with enable, flush and an occupancy count. Datapath blocks use it to align data with other pipelined paths and to retime buses between units.

## Interface
Parameters:
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 4: number of stages, ≥1. This is the latency in enabled cycles.
- `RESET_VALUE`, default 0: value loaded into every stage's data on reset. It is `WIDTH` bits wide.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: reset is synchronous and active-high.
- `en`  input  1: advance enable; when low the pipeline holds.
- `flush`  input  1: synchronous clear of all valid bits.
- `D`  input  `WIDTH`: input data.
- `d_valid`  input  1: qualifies `D`.
- `Q`  output  `WIDTH`: data of the last stage, driven directly from a register.
- `q_valid`  output  1: valid bit of the last stage.
- `occupancy`  output  `$clog2(DEPTH+1)`: number of stages holding valid data, 0..`DEPTH`, registered.
- `busy`  output  1: `occupancy != 0`.

## Operation
Per rising edge, the first matching rule wins:
- **`reset`=1:**
  - every stage data = `RESET_VALUE`
  - every valid = 0
  - `occupancy` = 0
  - `en`, `flush`, `D` and `d_valid` are ignored.
- **`flush`=1:**
  - every valid = 0 and `occupancy` = 0
  - stage data is unchanged, so `Q` keeps its last value
  - if `en`=1 on the same cycle, the input word is dropped.
- **`en`=1:**
  - stage[0] ← `D` and valid[0] ← `d_valid`
  - stage[i] ← stage[i-1] for i = 1..`DEPTH`-1, with valids shifting alongside.
  - Data is captured even when `d_valid`=0. Consumers use `q_valid` as the qualifier.
- **otherwise:** all state holds.

Occupancy rules:
- Occupancy is maintained incrementally: on an `en` cycle, `occupancy` ← `occupancy` + `d_valid` − valid[`DEPTH`-1].
- Simultaneous entry and exit leaves the count unchanged.
- The count never exceeds `DEPTH` and never underflows. Any violation is an RTL bug, and the bench asserts on it.

`DEPTH`=1 case:
- The block degenerates to a `WIDTH`-bit enabled D register with a valid bit.
- With `en`=1 held, `Q` follows `D` one cycle late.

## Timing
Reset values:
- `Q` = `RESET_VALUE`
- `q_valid` = 0
- `occupancy` = 0
- `busy` = 0

Latency:
- A word presented with `en`=1 at edge n appears on `Q` after edge n+`DEPTH`-1, i.e. it is visible during the cycle following the `DEPTH`-th enabled edge.
- Edges where `en`=0 add no progress.

Output timing:
- `Q`, `q_valid` and `occupancy` are pure register outputs.
- `busy` is a single comparator on the registered `occupancy`.

Input timing:
- There are no combinational paths from any input to any output.
- `en`, `flush` and `D` have no setup requirement relative to each other beyond the normal single-clock setup.

Reset during operation:
- Reset mid-stream takes effect on the next edge regardless of `en`.
- All in-flight words are discarded.

## Structure
Shared package `d_pipe_pkg`:
- occupancy-width helper function `occ_w(depth)` = `$clog2(depth+1)`
- default parameter constants `D_PIPE_WIDTH_DEF`, `D_PIPE_DEPTH_DEF`.

Sub-module `d_pipe_stage`:
- one stage: `WIDTH`-bit data register plus valid flop, with `clk`, `reset`, `en`, `flush`, `RESET_VALUE`.
- instantiated `DEPTH` times with a generate loop.

Top level holds only:
- the stage chain wiring
- the occupancy counter
- the `busy` comparator.

## Test plan
Use `WIDTH`=8 and `DEPTH`=4 unless stated otherwise.
- **Reset priority:** `reset`=1 for 2 edges with `en`=1, `d_valid`=1, `D`=8'hFF → `Q`=8'h00, `q_valid`=0, `occupancy`=0, `busy`=0 throughout.
- **Latency and fill:** `en`=1, push valid A1, A2, A3, A4 on consecutive edges → `occupancy` = 1, 2, 3, 4 after each edge; `Q`=A1 with `q_valid`=1 after the 4th edge; then A2 after the 5th edge with `occupancy` staying 4 while valid data continues.
- **Stall:** with the pipe full, `en`=0 for 3 edges while `D`=8'h55 → `Q`, `q_valid` and `occupancy` are frozen. Re-enabling resumes the sequence with no loss or duplication.
- **Bubbles:** inputs valid 8'h11, invalid 8'h22, valid 8'h33, then `d_valid`=0 → `q_valid` = 1, 0, 1 after edges 4, 5, 6, with `Q` = 8'h11, 8'h22, 8'h33; `occupancy` peaks at 2 and returns to 0.
- **Flush vs. enable:** with the pipe full, `flush`=1 and `en`=1 with `d_valid`=1, `D`=8'hAA → next cycle `occupancy`=0, `q_valid`=0, `Q` unchanged. 8'hAA never appears valid.
- **Mid-stream reset and DEPTH=1:** reset while full → all outputs return to reset values on the next edge. A second instance with `DEPTH`=1 and `RESET_VALUE`=8'h5A shows `Q`=8'h5A after reset, then `Q` = D(n-1) each cycle with `en`=1.
